// File: rtl/c432_bist_pkg.sv
// Shared definitions for the c432 response-compaction block.
//   - state_e        : controller states (IDLE, RUN, CHECK, DONE)
//   - C432_RESP_W    : number of c432 primary outputs folded per pattern
//   - RESP_Nxxx      : bit position of each c432 output inside the resp bus
package c432_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int C432_RESP_W = 7;

  localparam int RESP_N223 = 0;
  localparam int RESP_N329 = 1;
  localparam int RESP_N370 = 2;
  localparam int RESP_N421 = 3;
  localparam int RESP_N430 = 4;
  localparam int RESP_N431 = 5;
  localparam int RESP_N432 = 6;

endpackage

// File: rtl/c432_resp_misr_if.sv
// Bus bundle between the c432 pattern source / controller and the MISR block.
//   Requests : start, abort, golden[SIG_W], resp[7], resp_valid
//   Status   : busy, done, pass, signature[SIG_W], resp_count[COUNT_W]
// master drives the requests and observes status; slave is the MISR block.
interface c432_resp_misr_if
  import c432_bist_pkg::*;
#(
  parameter int SIG_W   = 16,
  parameter int COUNT_W = 16
);
  logic                   start;
  logic                   abort;
  logic [SIG_W-1:0]       golden;
  logic [C432_RESP_W-1:0] resp;
  logic                   resp_valid;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [SIG_W-1:0]       signature;
  logic [COUNT_W-1:0]     resp_count;

  modport master (
    output start, abort, golden, resp, resp_valid,
    input  busy, done, pass, signature, resp_count
  );

  modport slave (
    input  start, abort, golden, resp, resp_valid,
    output busy, done, pass, signature, resp_count
  );
endinterface

// File: rtl/c432_resp_misr_core.sv
// Galois-form multiple-input signature register.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (register -> SEED)
//   i_load         : reload SEED (wins over i_en)
//   i_en           : fold i_data into the signature this cycle
//   i_data[DIN_W]  : parallel input, zero-extended onto the low bits
//   o_sig[SIG_W]   : current register contents
module misr_core
  import c432_bist_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
  parameter int               DIN_W = C432_RESP_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIN_W-1:0] i_data,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_fb;
  logic [SIG_W-1:0] w_next;

  // Shift left; the bit falling out of the MSB selects the polynomial taps.
  assign w_fb   = r_sig[SIG_W-1] ? POLY : '0;
  assign w_next = {r_sig[SIG_W-2:0], 1'b0} ^ w_fb ^ {{(SIG_W-DIN_W){1'b0}}, i_data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_sig <= SEED;
    else if (i_load) r_sig <= SEED;
    else if (i_en)   r_sig <= w_next;
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/c432_resp_misr.sv
// Response compactor for the c432 benchmark: folds N_PATTERNS responses into
// a MISR, then compares the signature against a golden value sampled at start.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : c432_resp_misr_if.slave (start/abort/golden/resp/resp_valid in,
//                busy/done/pass/signature/resp_count out, all registered)
module c432_resp_misr
  import c432_bist_pkg::*;
#(
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] POLY       = 16'h1021,
  parameter logic [SIG_W-1:0] SEED       = 16'hFFFF,
  parameter int               COUNT_W    = 16,
  parameter int               N_PATTERNS = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  c432_resp_misr_if.slave     bus
);

  localparam logic [COUNT_W-1:0] LAST_BEAT = COUNT_W'(N_PATTERNS - 1);

  state_e             r_state;
  state_e             w_next;
  logic               w_load;
  logic               w_en;
  logic               w_check;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic [COUNT_W-1:0] r_count;
  logic [SIG_W-1:0]   r_golden;
  logic [SIG_W-1:0]   w_sig;

  misr_core #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED),
    .DIN_W (C432_RESP_W)
  ) u_misr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_load  (w_load),
    .i_en    (w_en),
    .i_data  (bus.resp),
    .o_sig   (w_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Abort is checked before resp_valid and before the CHECK update so a
  // cancelled run never produces a verdict.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_en    = 1'b0;
    w_check = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_next = S_IDLE;
        end else if (bus.resp_valid) begin
          w_en = 1'b1;
          if (r_count == LAST_BEAT) w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bus.abort) begin
          w_next = S_IDLE;
        end else begin
          w_next  = S_DONE;
          w_check = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_count  <= '0;
      r_golden <= '0;
    end else begin
      r_busy <= (w_next == S_RUN) || (w_next == S_CHECK);
      if (w_load) begin
        r_count  <= '0;
        r_golden <= bus.golden;
        r_done   <= 1'b0;
        r_pass   <= 1'b0;
      end else if (w_en) begin
        r_count <= r_count + 1'b1;
      end
      if (w_check) begin
        r_done <= 1'b1;
        r_pass <= (w_sig == r_golden);
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.signature  = w_sig;
  assign bus.resp_count = r_count;

endmodule

// File: tb/tb_c432_resp_misr.sv
module tb_c432_resp_misr;
  import c432_bist_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // A: SEED=0, N=4   B: SEED=8000, N=1   C: defaults SEED=FFFF, N=16
  c432_resp_misr_if #(.SIG_W(16), .COUNT_W(16)) ia ();
  c432_resp_misr_if #(.SIG_W(16), .COUNT_W(16)) ib ();
  c432_resp_misr_if #(.SIG_W(16), .COUNT_W(16)) ic ();

  c432_resp_misr #(.SIG_W(16), .POLY(16'h1021), .SEED(16'h0000), .COUNT_W(16), .N_PATTERNS(4))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  c432_resp_misr #(.SIG_W(16), .POLY(16'h1021), .SEED(16'h8000), .COUNT_W(16), .N_PATTERNS(1))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  c432_resp_misr #(.SIG_W(16), .POLY(16'h1021), .SEED(16'hFFFF), .COUNT_W(16), .N_PATTERNS(16))
    u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signature as polynomial over GF(2); multiply by x, reduce by
  // x^16 + POLY, then add the response word.
  function automatic int unsigned m_step(input int unsigned s, input int unsigned r);
    int unsigned t;
    t = s * 2;
    if (t >= 32'h10000) t = (t - 32'h10000) ^ 32'h1021;
    return t ^ r;
  endfunction

  typedef struct {
    logic        v;
    logic [15:0] sig;
    logic [15:0] cnt;
    logic        busy;
    logic        done;
    logic        pass;
  } vec_t;

  task automatic run4_a(input logic [15:0] g, input logic exp_pass);
    logic [15:0] steps [4];
    steps[0] = 16'h0001; steps[1] = 16'h0003; steps[2] = 16'h0007; steps[3] = 16'h000F;
    ia.golden = g; ia.start = 1'b1; tick(); ia.start = 1'b0;
    chk("a_start_sig", ia.signature, 16'h0000);
    chk("a_start_busy", ia.busy, 1);
    ia.resp = 7'h01; ia.resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("a_step%0d_sig", i), ia.signature, steps[i]);
      chk($sformatf("a_step%0d_cnt", i), ia.resp_count, i + 1);
    end
    ia.resp_valid = 1'b0;
    chk("a_in_check_done", ia.done, 0);
    chk("a_in_check_busy", ia.busy, 1);
    tick();
    chk("a_done", ia.done, 1);
    chk("a_pass", ia.pass, exp_pass);
    chk("a_done_busy", ia.busy, 0);
    chk("a_final_sig", ia.signature, 16'h000F);
    tick();
    chk("a_hold_done", ia.done, 1);
    chk("a_hold_pass", ia.pass, exp_pass);
  endtask

  vec_t tbl [8];
  int unsigned resps [16];
  int unsigned msig;
  logic [15:0] gold;
  logic        want_pass;
  int          beats;
  int          cyc;

  initial begin
    tbl[0] = '{1'b1, 16'h0001, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'h0001, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 16'h0001, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 16'h0003, 16'd2, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 16'h0007, 16'd3, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 16'h0007, 16'd3, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 16'h000F, 16'd4, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 16'h000F, 16'd4, 1'b0, 1'b1, 1'b1};

    {ia.start, ia.abort, ia.golden, ia.resp, ia.resp_valid} = '0;
    {ib.start, ib.abort, ib.golden, ib.resp, ib.resp_valid} = '0;
    {ic.start, ic.abort, ic.golden, ic.resp, ic.resp_valid} = '0;

    #12;
    chk("rst_sig_a", ia.signature, 16'h0000);
    chk("rst_sig_c", ic.signature, 16'hFFFF);
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_pass", ia.pass, 0);
    chk("rst_cnt", ia.resp_count, 0);
    rst_n = 1'b1;
    tick();
    // resp_valid in IDLE is ignored
    ia.resp = 7'h55; ia.resp_valid = 1'b1; tick(); ia.resp_valid = 1'b0;
    chk("idle_valid_sig", ia.signature, 16'h0000);
    chk("idle_valid_cnt", ia.resp_count, 0);

    run4_a(16'h000F, 1'b1);
    run4_a(16'h000E, 1'b0);

    // Gapped valids, table-driven
    ia.golden = 16'h000F; ia.start = 1'b1; tick(); ia.start = 1'b0;
    ia.resp = 7'h01;
    for (int i = 0; i < 8; i++) begin
      ia.resp_valid = tbl[i].v;
      tick();
      chk($sformatf("tbl%0d_sig", i), ia.signature, tbl[i].sig);
      chk($sformatf("tbl%0d_cnt", i), ia.resp_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_busy", i), ia.busy, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), ia.done, tbl[i].done);
      chk($sformatf("tbl%0d_pass", i), ia.pass, tbl[i].pass);
    end
    ia.resp_valid = 1'b0;

    // start and abort together in DONE: start wins
    ia.start = 1'b1; ia.abort = 1'b1; tick(); ia.start = 1'b0; ia.abort = 1'b0;
    chk("st_ab_busy", ia.busy, 1);
    chk("st_ab_done", ia.done, 0);
    chk("st_ab_cnt", ia.resp_count, 0);
    // two beats then abort
    ia.resp_valid = 1'b1; tick(); tick(); ia.resp_valid = 1'b0;
    chk("pre_abort_sig", ia.signature, 16'h0003);
    ia.abort = 1'b1; ia.resp_valid = 1'b1; tick(); ia.abort = 1'b0; ia.resp_valid = 1'b0;
    chk("abort_busy", ia.busy, 0);
    chk("abort_done", ia.done, 0);
    chk("abort_pass", ia.pass, 0);
    chk("abort_sig_hold", ia.signature, 16'h0003);
    chk("abort_cnt_hold", ia.resp_count, 2);
    ia.abort = 1'b1; tick(); ia.abort = 1'b0;
    chk("idle_abort_noop", ia.signature, 16'h0003);
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    chk("restart_sig", ia.signature, 16'h0000);
    chk("restart_cnt", ia.resp_count, 0);
    chk("restart_busy", ia.busy, 1);
    // abort during CHECK
    ia.resp_valid = 1'b1; for (int i = 0; i < 4; i++) tick(); ia.resp_valid = 1'b0;
    ia.abort = 1'b1; tick(); ia.abort = 1'b0;
    chk("abort_check_done", ia.done, 0);
    chk("abort_check_busy", ia.busy, 0);
    tick();
    chk("abort_check_stays", ia.done, 0);

    // Feedback path, N=1
    ib.golden = 16'h1021; ib.start = 1'b1; tick(); ib.start = 1'b0;
    chk("b_start_sig", ib.signature, 16'h8000);
    ib.resp = 7'h00; ib.resp_valid = 1'b1; tick(); ib.resp_valid = 1'b0;
    chk("b_fb_sig", ib.signature, 16'h1021);
    chk("b_cnt", ib.resp_count, 1);
    chk("b_done_early", ib.done, 0);
    tick();
    chk("b_done", ib.done, 1);
    chk("b_pass", ib.pass, 1);

    // start during RUN ignored
    ia.golden = 16'h000F; ia.start = 1'b1; tick(); ia.start = 1'b0;
    ia.resp = 7'h01; ia.resp_valid = 1'b1; tick(); tick();
    ia.golden = 16'h0000; ia.start = 1'b1; tick(); ia.start = 1'b0;
    chk("busy_start_cnt", ia.resp_count, 3);
    tick(); ia.resp_valid = 1'b0;
    tick();
    chk("busy_start_done", ia.done, 1);
    chk("busy_start_pass", ia.pass, 1);
    // async reset mid-run
    ia.golden = 16'h000F; ia.start = 1'b1; tick(); ia.start = 1'b0;
    ia.resp_valid = 1'b1; tick(); tick(); ia.resp_valid = 1'b0;
    #2 rst_n = 1'b0; #1;
    chk("arst_sig", ia.signature, 16'h0000);
    chk("arst_busy", ia.busy, 0);
    chk("arst_cnt", ia.resp_count, 0);
    chk("arst_done", ia.done, 0);
    #3 rst_n = 1'b1;
    tick();
    ia.resp_valid = 1'b1; tick(); ia.resp_valid = 1'b0;
    chk("arst_idle", ia.signature, 16'h0000);

    // Randomized runs on C against the reference model
    for (int run = 0; run < 6; run++) begin
      msig = 32'hFFFF;
      for (int i = 0; i < 16; i++) begin
        resps[i] = $urandom_range(0, 127);
        msig = m_step(msig, resps[i]);
      end
      want_pass = run[0];
      gold = want_pass ? msig[15:0] : (msig[15:0] ^ (16'h1 << $urandom_range(0, 15)));
      ic.golden = gold; ic.start = 1'b1;
      ic.resp = 7'h7F; ic.resp_valid = 1'b1;
      tick(); ic.start = 1'b0;
      chk("c_start_sig", ic.signature, 16'hFFFF);
      chk("c_start_cnt", ic.resp_count, 0);
      msig = 32'hFFFF;
      beats = 0;
      cyc = 0;
      while (beats < 16 && cyc < 200) begin
        ic.resp_valid = ($urandom_range(0, 2) != 0);
        ic.resp = ic.resp_valid ? resps[beats][6:0] : 7'($urandom_range(0, 127));
        if (ic.resp_valid) begin
          msig = m_step(msig, resps[beats]);
          beats++;
        end
        tick();
        cyc++;
        chk("c_sig", ic.signature, msig);
        chk("c_cnt", ic.resp_count, beats);
      end
      if (beats < 16) chk("c_cycle_budget", beats, 16);
      ic.resp_valid = 1'b1;
      tick();
      ic.resp_valid = 1'b0;
      chk("c_check_ignores_valid", ic.signature, msig);
      chk("c_done", ic.done, 1);
      chk("c_pass", ic.pass, want_pass);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
